// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - shared flit constants, types and route FSM states
package noc_flit_pkg;

  localparam int FLIT_W       = 9;
  localparam int TAIL_BIT     = FLIT_W - 1;
  localparam int ADDR_LSB_DEF = 0;
  localparam int LEVEL_DEF    = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } route_state_t;

  // Tail flag of a flit; closes the current packet
  function automatic logic is_tail(flit_t f);
    return f[TAIL_BIT];
  endfunction

endpackage

// File: rtl/route_sel_gen_if.sv
// rtl/route_sel_gen_if.sv - flit input stream plus flit/select output token channels
interface route_sel_gen_if;
  import noc_flit_pkg::*;

  flit_t in_flit;
  logic  in_valid;
  logic  in_ready;

  flit_t out_flit;
  logic  out_valid;
  logic  out_ready;

  logic  sel;
  logic  sel_valid;
  logic  sel_ready;

  // Producer of flits / consumer of both tokens
  modport master (
    output in_flit, in_valid, out_ready, sel_ready,
    input  in_ready, out_flit, out_valid, sel, sel_valid
  );

  // The route stage itself
  modport slave (
    input  in_flit, in_valid, out_ready, sel_ready,
    output in_ready, out_flit, out_valid, sel, sel_valid
  );

endinterface

// File: rtl/route_sel_gen_fork2_reg.sv
// rtl/route_sel_gen_fork2_reg.sv - one-entry register forked to two independent consumers
module fork2_reg #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         a_valid_o,
  input  logic         a_ready_i,
  output logic         b_valid_o,
  input  logic         b_ready_i,
  output logic         retire_o
);

  logic [W-1:0] data_q;
  logic         full_q, full_d;
  logic         a_taken_q, a_taken_d;
  logic         b_taken_q, b_taken_d;
  logic         a_done, b_done, load;

  // Each side sees its token until it handshakes once; the entry leaves
  // only when both sides have taken it, in either order or together.
  always_comb begin
    a_valid_o = full_q && !a_taken_q && !rst_i;
    b_valid_o = full_q && !b_taken_q && !rst_i;
    a_done    = a_taken_q || (a_valid_o && a_ready_i);
    b_done    = b_taken_q || (b_valid_o && b_ready_i);
    retire_o  = full_q && a_done && b_done && !rst_i;
    ready_o   = !rst_i && (!full_q || retire_o);
    load      = valid_i && ready_o;
    full_d    = load || (full_q && !retire_o);
    a_taken_d = retire_o ? 1'b0 : a_done;
    b_taken_d = retire_o ? 1'b0 : b_done;
  end

  // Entry state; a new word may load in the same cycle the old one retires
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q    <= 1'b0;
      a_taken_q <= 1'b0;
      b_taken_q <= 1'b0;
      data_q    <= '0;
    end else begin
      full_q    <= full_d;
      a_taken_q <= a_taken_d;
      b_taken_q <= b_taken_d;
      if (load) data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/route_sel_gen.sv
// rtl/route_sel_gen.sv - packet-tracking select generator feeding a 1-to-2 leaf decoder
module route_sel_gen
  import noc_flit_pkg::*;
#(
  parameter int ADDR_LSB = ADDR_LSB_DEF,
  parameter int LEVEL    = LEVEL_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  route_sel_gen_if.slave   bus,
  output logic [CNT_W-1:0] pkt_count,
  output logic             in_pkt
);

  localparam int SEL_BIT = ADDR_LSB + LEVEL;

  route_state_t     state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_tok, accept, retire;
  logic [FLIT_W:0]  ent;

  assign accept = bus.in_valid && bus.in_ready;

  // Header picks the select from its address bit; body flits reuse it
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sel_tok = sel_q;
    if (state_q == HEAD) sel_tok = bus.in_flit[SEL_BIT];
    if (accept) begin
      sel_d   = sel_tok;
      state_d = is_tail(bus.in_flit) ? HEAD : BODY;
    end
    if (retire && is_tail(ent[FLIT_W:1])) cnt_d = cnt_q + CNT_W'(1);
  end

  // FSM, select latch and completed-packet counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= HEAD;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  fork2_reg #(.W(FLIT_W + 1)) u_fork (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .data_i    ({bus.in_flit, sel_tok}),
    .valid_i   (bus.in_valid),
    .ready_o   (bus.in_ready),
    .data_o    (ent),
    .a_valid_o (bus.out_valid),
    .a_ready_i (bus.out_ready),
    .b_valid_o (bus.sel_valid),
    .b_ready_i (bus.sel_ready),
    .retire_o  (retire)
  );

  assign bus.out_flit = ent[FLIT_W:1];
  assign bus.sel      = ent[0];
  assign pkt_count    = cnt_q;
  assign in_pkt       = (state_q == BODY);

endmodule

// File: tb/tb_route_sel_gen.sv
// tb/tb_route_sel_gen.sv - scoreboard bench for route_sel_gen
module tb_route_sel_gen;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] pkt_count;
  logic       in_pkt;

  route_sel_gen_if bus ();

  route_sel_gen #(.ADDR_LSB(0), .LEVEL(0), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .pkt_count (pkt_count),
    .in_pkt    (in_pkt)
  );

  always #5 CLK = ~CLK;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         cyc    = 0;
  logic [8:0] exp_flit_q[$];
  logic       exp_sel_q[$];
  logic       m_head = 1'b1;
  logic       m_sel  = 1'b0;
  int         m_cnt  = 0;
  int         acc_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Pop and compare each token as its side handshakes
  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_flit_q.size() == 0) check_eq("flit_extra", 1, 0);
        else check_eq("flit", 32'(bus.out_flit), 32'(exp_flit_q.pop_front()));
      end
      if (bus.sel_valid && bus.sel_ready) begin
        if (exp_sel_q.size() == 0) check_eq("sel_extra", 1, 0);
        else check_eq("sel", 32'(bus.sel), 32'(exp_sel_q.pop_front()));
      end
    end
  end

  // Offer a flit, push its expected tokens on acceptance; returns #1 after the accepting edge
  task automatic send(input logic [8:0] f);
    bit ok = 0;
    bus.in_flit  = f;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        ok = 1;
        acc_cyc = cyc;
        if (m_head) m_sel = f[0];
        m_head = f[8];
        exp_flit_q.push_back(f);
        exp_sel_q.push_back(m_sel);
        if (f[8]) m_cnt++;
      end
      @(posedge CLK);
      #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (exp_flit_q.size() == 0 && exp_sel_q.size() == 0 && !bus.out_valid && !bus.sel_valid) begin
        ok = 1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    if (!ok) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_flit_q.delete();
    exp_sel_q.delete();
    m_head = 1'b1;
    m_sel  = 1'b0;
    m_cnt  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    RESET         = 1'b1;
    bus.in_flit   = 9'h101;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.sel_ready = 1'b1;

    // Reset held two cycles with a flit offered
    @(posedge CLK);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_sel_valid", 32'(bus.sel_valid), 0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 0);
    check_eq("rst_pkt_count", 32'(pkt_count), 0);
    @(posedge CLK);
    #1;
    check_eq("rst_in_ready2", 32'(bus.in_ready), 0);
    RESET = 1'b0;
    send(9'h101);
    drain();
    check_eq("post_rst_cnt", 32'(pkt_count), 32'(m_cnt & 15));

    // Three-flit packet, full throughput, select 0
    send(9'h002);
    c0 = acc_cyc;
    check_eq("lat_out_valid", 32'(bus.out_valid), 1);
    check_eq("lat_out_flit", 32'(bus.out_flit), 32'h002);
    check_eq("in_pkt_hdr", 32'(in_pkt), 1);
    send(9'h055);
    c1 = acc_cyc;
    check_eq("tput1", 32'(c1 - c0), 1);
    send(9'h1AA);
    check_eq("tput2", 32'(acc_cyc - c1), 1);
    check_eq("cnt_before_retire", 32'(pkt_count), 32'((m_cnt - 1) & 15));
    @(posedge CLK);
    #1;
    check_eq("cnt_after_retire", 32'(pkt_count), 32'(m_cnt & 15));
    drain();

    // Two-flit packet with select 1
    send(9'h001);
    check_eq("in_pkt_sel1", 32'(in_pkt), 1);
    send(9'h100);
    check_eq("in_pkt_tail", 32'(in_pkt), 0);
    drain();

    // Flit side stalled while select side accepts
    bus.out_ready = 1'b0;
    send(9'h103);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check_eq("skew_sel_valid", 32'(bus.sel_valid), 0);
      check_eq("skew_out_valid", 32'(bus.out_valid), 1);
      check_eq("skew_out_flit", 32'(bus.out_flit), 32'h103);
      check_eq("skew_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("skew_retire_ready", 32'(bus.in_ready), 1);
    drain();
    check_eq("skew_cnt", 32'(pkt_count), 32'(m_cnt & 15));

    // Back-to-back single-flit packets
    send(9'h101);
    send(9'h100);
    send(9'h101);
    drain();
    check_eq("b2b_cnt", 32'(pkt_count), 32'(m_cnt & 15));

    // Reset in the middle of a packet
    pulse_reset();
    check_eq("pre_mid_cnt", 32'(pkt_count), 0);
    send(9'h001);
    drain();
    check_eq("mid_in_pkt", 32'(in_pkt), 1);
    pulse_reset();
    check_eq("mid_rst_in_pkt", 32'(in_pkt), 0);
    check_eq("mid_rst_cnt", 32'(pkt_count), 0);
    send(9'h100);
    drain();
    check_eq("mid_cnt", 32'(pkt_count), 1);

    // Counter wrap with a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 17; i++) send(9'h100 | 9'(i & 1));
    drain();
    check_eq("wrap_cnt", 32'(pkt_count), 1);
    check_eq("wrap_model", 32'(pkt_count), 32'(m_cnt & 15));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/route_sel_gen.md
Name: route_sel_gen

Overview:
- Clocked stage directly upstream of the 1-to-2 leaf decoder. Consumes a 9-bit flit stream, tracks packet boundaries, and emits one 9-bit flit token plus one 1-bit select token per flit.
- The select is taken from the header flit's destination address and held for every flit of the packet.
- Output sides feed the decoder's In and S channels through the sync-to-async bridge.

Parameters:
- FLIT_W, 9, flit width; bit FLIT_W-1 is the tail flag, bits FLIT_W-2:0 are the payload.
- ADDR_LSB, 0, payload bit index of the destination-address field in header flits.
- LEVEL, 0, address bit (relative to ADDR_LSB) that steers this leaf; sel = payload[ADDR_LSB+LEVEL].
- CNT_W, 16, width of the packet counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_flit  in  FLIT_W  incoming flit.
- in_valid  in  1  in_flit valid.
- in_ready  out  1  stage can accept a flit.
- out_flit  out  FLIT_W  flit token toward decoder In.
- out_valid  out  1  out_flit valid.
- out_ready  in  1  decoder In side accepts.
- sel  out  1  select token toward decoder S (0 = Out0, 1 = Out1).
- sel_valid  out  1  sel valid.
- sel_ready  in  1  decoder S side accepts.
- pkt_count  out  CNT_W  number of completed packets (tail flits forwarded).
- in_pkt  out  1  high while between a header and its tail (state BODY).

Behaviour:
- Reset (RESET high at a rising CLK edge):
  - out_valid = 0, sel_valid = 0, in_ready = 0 during the reset cycle.
  - pkt_count = 0, state = HEAD, held select = 0, both taken flags cleared.
  - Any in-flight token is discarded. Reset mid-packet means the next accepted flit is treated as a header.
- FSM states:
  - HEAD: the next accepted flit is a header. sel_next = in_flit[ADDR_LSB+LEVEL]; the select register is latched.
    - If the header's tail bit = 1 (single-flit packet), stay in HEAD.
    - Otherwise go to BODY.
  - BODY: accepted flits reuse the latched select. A flit with tail = 1 returns the FSM to HEAD; pkt_count increments when that flit is fully delivered.
- Output register:
  - One-entry register holding {flit, sel}.
  - Accept at an edge when in_valid && in_ready. out_valid and sel_valid both rise the next cycle, so latency is 1 cycle from acceptance to valid.
- Fork/join on output:
  - Two sticky flags, f_taken and s_taken.
  - out_valid = full && !f_taken; sel_valid = full && !s_taken.
  - A flag sets on (valid && ready) for its side.
  - The entry retires when both sides are done. This includes both accepting in the same cycle, or one side now plus the other's flag already set.
  - On retire, both flags clear.
- Input ready:
  - in_ready = !RESET && (!full || retire_this_cycle), so a full-throughput pipe is possible (1 flit/cycle when both readies stay high).
  - A new flit can load in the same cycle the old entry retires.
- Stability: once out_valid or sel_valid is asserted, its data is stable until the handshake on that side.
- pkt_count:
  - Increments by 1 on retire of a flit whose tail bit = 1.
  - Wraps modulo 2^CNT_W with no saturation.
- in_pkt: 1 in BODY, 0 in HEAD. It updates on acceptance, not on retire.
- No flits are dropped or reordered. A select token is never emitted without its flit, and vice versa.

Decomposition:
- Shared package noc_flit_pkg:
  - FLIT_W, TAIL_BIT and the address-field constants.
  - typedef flit_t (logic [FLIT_W-1:0]).
  - enum route_state_t {HEAD, BODY}.
- One natural sub-module: fork2_reg. It is the one-entry register with a two-consumer fork/join (taken flags, retire logic), parameterised on payload width.
- route_sel_gen holds the FSM, the select latch and the counter.

Test Plan:
- Reset: assert RESET 2 cycles with in_valid = 1 -> out_valid = sel_valid = 0, in_ready = 0, pkt_count = 0; first flit after release is treated as a header.
- Single packet, both readies = 1: with LEVEL = 0, feed header 0x002, then 0x055, then tail 0x1AA -> three tokens, each 1 cycle after acceptance, sel = 0,0,0; pkt_count goes 0 -> 1 after the third retires; throughput 1 flit/cycle.
- Header select 1: feed header 0x001 then tail 0x100 -> sel = 1,1; in_pkt = 1 after the header and 0 after the tail.
- Skewed consumers: sel_ready = 1 but out_ready held 0 for 3 cycles -> sel taken once, sel_valid drops; out_flit held stable; in_ready = 0 until out_ready = 1 retires the entry; no duplicate S token.
- Back-to-back single-flit packets 0x101, 0x100, 0x101 -> sel = 1,0,1 and pkt_count = 3.
- Mid-packet reset: after a header with sel = 1, pulse RESET, then send 0x100 -> it is treated as a header, so sel = 0 and pkt_count = 1.
- Counter wrap: with CNT_W = 4, send 17 single-flit packets -> pkt_count = 1.
